alu_operand_loader: RTL and testbench

Upstream command stage for the team's 16-bit ALU. It accepts a byte stream (valid/ready) carrying one opcode byte and two 16-bit operands, and drives stable a/b/sel into the combinational ALU. After a programmable settle time it captures the ALU's 32-bit result and holds it on a valid/ready result port. It also counts completed commands.

---
 rtl/alu_operand_loader.sv | 161 ++++++++++++++++
 tb/tb_alu_operand_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: byte-stream command front end for the 16-bit ALU.
// Collects an opcode byte and two little-endian 16-bit operands, drives
// them steadily into the combinational ALU, waits a programmable settle
// time, then captures the 32-bit ALU result behind a valid/ready port.
module alu_operand_loader #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [1:0]  sel,
  input  logic [31:0] alu_out,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic [7:0]  cmd_count
);

  typedef enum logic [2:0] {
    CMD    = 3'd0,
    A_LO   = 3'd1,
    A_HI   = 3'd2,
    B_LO   = 3'd3,
    B_HI   = 3'd4,
    SETTLE = 3'd5,
    RESULT = 3'd6
  } state_t;

  // Counter value on which the ALU output is considered settled.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  settle_cnt;
  logic [7:0]  settle_cnt_next;
  logic [15:0] a_next;
  logic [15:0] b_next;
  logic [1:0]  sel_next;
  logic [31:0] res_data_next;
  logic        res_valid_next;
  logic [7:0]  cmd_count_next;
  logic        xfer;

  // A byte moves only when both sides agree on the same edge.
  assign xfer = in_valid && in_ready;

  // Next-state and next-register computation; every register holds by default.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    a_next          = a;
    b_next          = b;
    sel_next        = sel;
    res_data_next   = res_data;
    res_valid_next  = res_valid;
    cmd_count_next  = cmd_count;
    in_ready        = 1'b0;
    case (state)
      CMD: begin
        in_ready = 1'b1;
        if (xfer) begin
          sel_next   = in_data[1:0];  // opcode upper bits are don't-care
          state_next = A_LO;
        end else begin
          state_next = CMD;
        end
      end
      A_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          a_next[7:0] = in_data;
          state_next  = A_HI;
        end else begin
          state_next = A_LO;
        end
      end
      A_HI: begin
        in_ready = 1'b1;
        if (xfer) begin
          a_next[15:8] = in_data;
          state_next   = B_LO;
        end else begin
          state_next = A_HI;
        end
      end
      B_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          b_next[7:0] = in_data;
          state_next  = B_HI;
        end else begin
          state_next = B_LO;
        end
      end
      B_HI: begin
        in_ready = 1'b1;
        if (xfer) begin
          b_next[15:8]    = in_data;
          settle_cnt_next = 8'd0;
          state_next      = SETTLE;
        end else begin
          state_next = B_HI;
        end
      end
      SETTLE: begin
        settle_cnt_next = settle_cnt + 8'd1;
        if (settle_cnt == SETTLE_LAST) begin
          res_data_next  = alu_out;
          res_valid_next = 1'b1;
          state_next     = RESULT;
        end else begin
          state_next = SETTLE;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          cmd_count_next = cmd_count + 8'd1;
          state_next     = CMD;
        end else begin
          state_next = RESULT;
        end
      end
      default: begin
        state_next     = CMD;
        res_valid_next = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CMD;
      settle_cnt <= 8'd0;
      a          <= 16'd0;
      b          <= 16'd0;
      sel        <= 2'd0;
      res_data   <= 32'd0;
      res_valid  <= 1'b0;
      cmd_count  <= 8'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      a          <= a_next;
      b          <= b_next;
      sel        <= sel_next;
      res_data   <= res_data_next;
      res_valid  <= res_valid_next;
      cmd_count  <= cmd_count_next;
    end
  end

  assign busy = (state != CMD);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed testbench for alu_operand_loader. Two instances: settle time 2
// for the functional tests and settle time 1 for the wrap/latency test.
// Each instance is fed by a small behavioural model of the 16-bit ALU.
module tb_alu_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // instance with SETTLE_CYCLES = 2
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [1:0]  sel;
  logic [31:0] alu_out;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic [7:0]  cmd_count;
  // instance with SETTLE_CYCLES = 1
  logic [7:0]  in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] a1, b1;
  logic [1:0]  sel1;
  logic [31:0] alu_out1;
  logic [31:0] res_data1;
  logic        res_valid1;
  logic        res_ready1;
  logic        busy1;
  logic [7:0]  cmd_count1;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural 16-bit ALU.
  function automatic logic [31:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] s);
    case (s)
      2'd0:    return {16'h0, x} + {16'h0, y};
      2'd1:    return {16'h0, x} - {16'h0, y};
      2'd2:    return {16'h0, x} * {16'h0, y};
      default: return {16'h0, x >> y};
    endcase
  endfunction

  assign alu_out  = alu_f(a, b, sel);
  assign alu_out1 = alu_f(a1, b1, sel1);

  alu_operand_loader #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .sel(sel), .alu_out(alu_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .cmd_count(cmd_count)
  );

  alu_operand_loader #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .a(a1), .b(b1), .sel(sel1), .alu_out(alu_out1),
    .res_data(res_data1), .res_valid(res_valid1), .res_ready(res_ready1),
    .busy(busy1), .cmd_count(cmd_count1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte to the settle-2 instance and wait (bounded) for it to be taken.
  task automatic send_byte(input logic [7:0] d);
    int k;
    k = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else tick();
    in_valid = 1'b0;
  endtask

  // Full five-byte command with 'gap' idle (in_valid low) cycles between bytes.
  task automatic send_cmd(input logic [7:0] c, input logic [7:0] al, input logic [7:0] ah,
                          input logic [7:0] bl, input logic [7:0] bh, input int gap);
    logic [7:0] bytes [5];
    bytes = '{c, al, ah, bl, bh};
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      if (i < 4) begin
        for (int g = 0; g < gap; g++) begin
          in_data = 8'hEE;
          tick();
        end
      end
    end
  endtask

  // Called just after the B_HI transfer edge: res_valid must rise exactly two edges later.
  task automatic wait_result(input string tag);
    chk({tag, "_lat0"}, 32'(res_valid), 32'd0);
    tick();
    chk({tag, "_lat1"}, 32'(res_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(res_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x, y;
    logic [7:0]  bytes1 [5];
    int          k;
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; res_ready = 1'b1;
    in_data1 = 8'h00; in_valid1 = 1'b0; res_ready1 = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_a",         32'(a),         32'd0);
    chk("rst_b",         32'(b),         32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  res_data,       32'd0);
    chk("rst_count",     32'(cmd_count), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // 1: add 0x1234 + 0x0001
    send_cmd(8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 0);
    chk("t1_a",   32'(a),   32'h1234);
    chk("t1_b",   32'(b),   32'h0001);
    chk("t1_sel", 32'(sel), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_result("t1");
    chk("t1_res", res_data, 32'h0000_1235);
    tick();
    chk("t1_pulse", 32'(res_valid), 32'd0);
    chk("t1_count", 32'(cmd_count), 32'd1);
    chk("t1_idle",  32'(busy),      32'd0);
    chk("t1_keep",  res_data,       32'h0000_1235);

    // 2: sub with junk opcode bits, then mul
    send_cmd(8'hFD, 8'h05, 8'h00, 8'h03, 8'h00, 0);
    chk("t2_sel", 32'(sel), 32'd1);
    wait_result("t2s");
    chk("t2_sub", res_data, 32'h0000_0002);
    tick();
    send_cmd(8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 0);
    wait_result("t2m");
    chk("t2_mul", res_data, 32'h0001_0000);
    tick();
    chk("t2_count", 32'(cmd_count), 32'd3);

    // 3: backpressure on the result port
    res_ready = 1'b0;
    send_cmd(8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 0);
    wait_result("t3");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      chk("t3_hold_valid", 32'(res_valid), 32'd1);
      chk("t3_hold_data",  res_data,       32'h0000_1235);
      chk("t3_in_ready",   32'(in_ready),  32'd0);
    end
    res_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t3_busy",  32'(busy),      32'd0);
    chk("t3_valid", 32'(res_valid), 32'd0);
    chk("t3_count", 32'(cmd_count), 32'd4);
    chk("t3_a",     32'(a),         32'h1234);
    chk("t3_sel",   32'(sel),       32'd0);
    chk("t3_keep",  res_data,       32'h0000_1235);

    // 4: in_valid toggled 1-0-0-1 between bytes
    send_cmd(8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 2);
    chk("t4_a", 32'(a), 32'h1234);
    chk("t4_b", 32'(b), 32'h0001);
    wait_result("t4");
    chk("t4_res", res_data, 32'h0000_1235);
    tick();
    chk("t4_count", 32'(cmd_count), 32'd5);

    // 5: reset in B_LO, then a clean shift-right command
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy",     32'(busy),      32'd0);
    chk("t5_a",        32'(a),         32'd0);
    chk("t5_b",        32'(b),         32'd0);
    chk("t5_sel",      32'(sel),       32'd0);
    chk("t5_in_ready", 32'(in_ready),  32'd1);
    chk("t5_count",    32'(cmd_count), 32'd0);
    chk("t5_res_data", res_data,       32'd0);
    send_cmd(8'h03, 8'h08, 8'h00, 8'h02, 8'h00, 0);
    wait_result("t5");
    chk("t5_shr", res_data, 32'h0000_0002);
    tick();
    chk("t5_count2", 32'(cmd_count), 32'd1);

    // 6: 256 add commands on the settle-1 instance; count wraps to 0
    for (int c = 0; c < 256; c++) begin
      x = 16'(c * 257 + 1);
      y = 16'(c * 3);
      bytes1 = '{8'h00, x[7:0], x[15:8], y[7:0], y[15:8]};
      for (int i = 0; i < 5; i++) begin
        in_data1  = bytes1[i];
        in_valid1 = 1'b1;
        k = 0;
        while (!in_ready1 && k < 50) begin
          tick();
          k++;
        end
        if (!in_ready1) chk("t6_in_ready_timeout", 32'(in_ready1), 32'd1);
        else tick();
      end
      in_valid1 = 1'b0;
      chk("t6_lat0", 32'(res_valid1), 32'd0);
      tick();
      chk("t6_lat1", 32'(res_valid1), 32'd1);
      chk("t6_res",  res_data1,       {16'h0, x} + {16'h0, y});
      tick();
      if (c == 0) chk("t6_count1", 32'(cmd_count1), 32'd1);
    end
    chk("t6_wrap", 32'(cmd_count1), 32'd0);
    chk("t6_busy", 32'(busy1),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
